// File: rtl/frqdivmod.sv
// frqdivmod: integer clock divider producing signal_out with a period of DIV clk cycles.
// Ports: clk (rising-edge clock), rst (async active-low reset), signal_out (registered divided clock).
// Latency: signal_out reflects the post-edge count on the same edge; no enable and no backpressure, free-running.
module frqdivmod #(
  parameter int DIV = 2,
  parameter int W   = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
  output logic signal_out
);

  // Keep declarations legal even when DIV is rejected below, so the only
  // diagnostic raised is the intended one.
  localparam int WI = (W < 1) ? 1 : W;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("frqdivmod: DIV must be >= 2");
    end
  endgenerate

  // Terminal count and the first count value of the high phase,
  // H = ceil(DIV/2), so that the low phase is never shorter than the high phase.
  localparam logic [WI-1:0] LAST = WI'(DIV - 1);
  localparam logic [WI-1:0] HI_START = WI'((DIV + 1) / 2);

  logic [WI-1:0] r_cnt;
  logic          r_out;
  logic [WI-1:0] w_cnt_nxt;

  // Explicit wrap at LAST: when DIV is a power of two this coincides with the
  // natural rollover, otherwise it prevents the counter from ever reaching DIV.
  assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + WI'(1);

  // The output is compared against the next count and registered, so
  // signal_out always agrees with the count held after the same edge and
  // comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_out <= (w_cnt_nxt >= HI_START);
    end
  end

  assign signal_out = r_out;

endmodule

// File: tb/tb_frqdivmod.sv
// tb_frqdivmod: randomized checking of frqdivmod at DIV = 2, 3, 5, 16 and 1134 against an edge-count model.
// Ports: none; drives a shared clk and rst into five instances.
// Latency: outputs are sampled 1 time unit after each rising edge; asynchronous reset is exercised between edges.
module tb_frqdivmod;

  localparam int NI = 5;

  logic clk;
  logic rst;
  logic o2, o3, o5, o16, o1134;

  frqdivmod #(.DIV(2))    u_d2    (.clk(clk), .rst(rst), .signal_out(o2));
  frqdivmod #(.DIV(3))    u_d3    (.clk(clk), .rst(rst), .signal_out(o3));
  frqdivmod #(.DIV(5))    u_d5    (.clk(clk), .rst(rst), .signal_out(o5));
  frqdivmod #(.DIV(16))   u_d16   (.clk(clk), .rst(rst), .signal_out(o16));
  frqdivmod #(.DIV(1134)) u_d1134 (.clk(clk), .rst(rst), .signal_out(o1134));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int divs [NI] = '{2, 3, 5, 16, 1134};
  string names [NI] = '{"d2", "d3", "d5", "d16", "d1134"};

  // Reference state: number of rising edges seen with rst high since the last release.
  int n_edges;
  int obs_out [NI];
  int obs_cnt [NI];
  int prev_out [NI];
  int first_rise [NI];
  int rises [NI];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    obs_out[0] = int'(o2);
    obs_out[1] = int'(o3);
    obs_out[2] = int'(o5);
    obs_out[3] = int'(o16);
    obs_out[4] = int'(o1134);
    obs_cnt[0] = int'(u_d2.r_cnt);
    obs_cnt[1] = int'(u_d3.r_cnt);
    obs_cnt[2] = int'(u_d5.r_cnt);
    obs_cnt[3] = int'(u_d16.r_cnt);
    obs_cnt[4] = int'(u_d1134.r_cnt);
  endtask

  // Expected outputs come from the edge count alone: cnt = n mod DIV and
  // signal_out = 1 iff that value reaches ceil(DIV/2); both are 0 in reset.
  task automatic check_all(input string phase);
    sample();
    for (int i = 0; i < NI; i++) begin
      int exp_cnt;
      int exp_out;
      exp_cnt = (rst === 1'b1) ? (n_edges % divs[i]) : 0;
      exp_out = (rst === 1'b1 && exp_cnt >= (divs[i] + 1) / 2) ? 1 : 0;
      chk({phase, "_out_", names[i]}, obs_out[i], exp_out);
      chk({phase, "_cnt_", names[i]}, obs_cnt[i], exp_cnt);
      if (obs_out[i] == 1 && prev_out[i] == 0) begin
        rises[i]++;
        if (first_rise[i] < 0) first_rise[i] = n_edges;
      end
      prev_out[i] = obs_out[i];
    end
  endtask

  task automatic clear_tracking();
    n_edges = 0;
    for (int i = 0; i < NI; i++) begin
      prev_out[i] = 0;
      first_rise[i] = -1;
      rises[i] = 0;
    end
  endtask

  task automatic run_cycles(input int ncyc, input string phase);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      if (rst === 1'b1) n_edges++;
      #1;
      check_all(phase);
    end
  endtask

  // Release on a falling edge so the next rising edge is unambiguously n = 1.
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    clear_tracking();
  endtask

  // Assert reset between edges (2 units after a rising edge) and check the
  // outputs have already cleared before the next edge.
  task automatic async_reset(input string phase);
    @(posedge clk);
    if (rst === 1'b1) n_edges++;
    #2;
    rst = 1'b0;
    #1;
    check_all(phase);
  endtask

  int hi_run;
  int bad_runs;
  int waited;

  initial begin
    rst = 1'b1;
    clear_tracking();
    #2;
    rst = 1'b0;
    #1;
    check_all("por");
    run_cycles(3, "hold");

    // Long run covering the full DIV=1134 period and its phase boundaries.
    release_rst();
    run_cycles(1200, "run1");
    chk("d1134_first_high_edge", first_rise[4], 567);
    chk("d2_first_high_edge", first_rise[0], 1);
    chk("d3_first_high_edge", first_rise[1], 2);
    chk("d1134_rises_in_1200", rises[4], 1);

    // Random run lengths with asynchronous reset pulses landing mid-period.
    for (int k = 0; k < 8; k++) begin
      run_cycles($urandom_range(1, 400), "rand");
      async_reset("arst");
      run_cycles($urandom_range(1, 3), "rhold");
      release_rst();
    end

    // DIV=5: pull reset while its output is high, then check restart timing.
    waited = 0;
    while (o5 !== 1'b1 && waited < 10) begin
      run_cycles(1, "d5wait");
      waited++;
    end
    chk("d5_reached_high", int'(o5 === 1'b1), 1);
    async_reset("d5arst");
    chk("d5_low_before_edge", int'(o5), 0);
    run_cycles(2, "d5hold");
    release_rst();
    run_cycles(6, "d5run");
    chk("d5_first_high_edge", first_rise[2], 3);

    // DIV=16 long run: rising-edge count and every complete high phase length.
    async_reset("d16arst");
    release_rst();
    hi_run = 0;
    bad_runs = 0;
    for (int c = 0; c < 10000; c++) begin
      run_cycles(1, "d16");
      if (obs_out[3] == 1) begin
        hi_run++;
      end else begin
        if (hi_run != 0 && hi_run != 8) bad_runs++;
        hi_run = 0;
      end
    end
    chk("d16_rises", rises[3], (10000 - 8) / 16 + 1);
    chk("d16_bad_high_runs", bad_runs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frqdivmod.md
FRQDIVMOD -- requirements
Module: frqdivmod

Interface
REQ-001 Parameter DIV, default 2, meaning: integer clock division ratio; signal_out period = DIV clk cycles; legal range 2..2^24.
REQ-002 Parameter W, default $clog2(DIV), meaning: counter width derived from DIV; not intended for override.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-low.
REQ-005 Port signal_out  output  1  divided clock, driven directly from a flip-flop (glitch-free).

Function
REQ-006 Module SHALL hold a counter cnt of width W.
- After each rising clk edge with rst high, cnt SHALL advance: 0,1,...,DIV-1,0,...
- Wrap from DIV-1 to 0 SHALL occur in a single cycle, with no extra idle cycle.
REQ-007 Let H = ceil(DIV/2) (low phase) and L = floor(DIV/2) (high phase).
REQ-008 signal_out after an edge SHALL be 1 iff the post-edge cnt value is >= H; otherwise 0.
- Implementation: registered compare on the next-count value, no combinational output path.
REQ-009 Duty cycle: signal_out SHALL be low for H cycles and high for L cycles per period.
- Even DIV gives exactly 50%.
- Odd DIV gives a low phase one cycle longer than the high phase.
REQ-010 Timing after reset release, with n = number of rising edges since release (first edge n=1):
- cnt = n mod DIV;
- signal_out = 1 iff (n mod DIV) >= H.
REQ-011 First signal_out rising transition SHALL occur on edge n = H; subsequent rising transitions every DIV edges.
REQ-012 DIV = 2: signal_out SHALL toggle every clk edge, beginning high on edge 1.
REQ-013 DIV < 2: SHALL be rejected at elaboration by a generate-time error, not silently mis-divided.
REQ-014 Arithmetic:
- Counter compare SHALL be unsigned at width W.
- The counter SHALL never hold a value >= DIV.
- DIV = 2^W SHALL wrap correctly without an overflow cycle.
REQ-015 The block SHALL have no enable input; counting is free-running whenever rst is high.

Reset
REQ-016 While rst is low, cnt SHALL be 0 and signal_out SHALL be 0, asynchronously, without waiting for a clk edge.
REQ-017 Reset asserted mid-period SHALL immediately clear cnt and signal_out, including while signal_out is high.
- The period restarts from n=0 on release.
REQ-018 Reset deassertion SHALL take effect at the first rising clk edge on which rst is sampled high.
- That edge counts as n=1.
REQ-019 There SHALL be no other initialisation dependency; no reliance on initial blocks.

Verification
REQ-020 DIV=1134, clk 50 MHz, reset released at t0:
- signal_out low for edges 1..566, high at edge 567, low again at edge 1134;
- period 1134 cycles (about 44.09 kHz);
- high for 567 cycles.
REQ-021 DIV=2:
- signal_out sequence after release is 1,0,1,0,... on successive edges;
- cnt alternates 1,0.
REQ-022 DIV=3:
- post-edge cnt 1,2,0,1,2,0;
- signal_out 0,1,0,0,1,0;
- low 2 cycles, high 1 cycle.
REQ-023 DIV=5, rst pulled low asynchronously between edges while signal_out=1:
- signal_out drops to 0 before the next edge;
- after release, first high occurs on edge 3.
REQ-024 DIV=16, run 10000 cycles:
- cnt never exceeds 15;
- every period is exactly 16 cycles with 8 high;
- rising-edge count = floor((cycles - 8)/16) + 1.
